microondas_ctrl_param: RTL and testbench

Parametrised successor to the microwave front-end controller. It contains the following functions:
- button edge detection
- IDLE/RUN/PAUSE/DONE state machine
- saturating mm:ss time entry and 1 Hz countdown
- N-level power selection with time-proportional magnetron duty cycling
- door interlock
- timed end-of-cycle beeper

It produces binary time and status for the separate display/driver blocks. It drives no segments itself.

---
 rtl/microondas_ctrl_param_if.sv | 44 ++++
 rtl/microondas_ctrl_param.sv | 206 ++++++++++++++++++++
 tb/tb_microondas_ctrl_param.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/microondas_ctrl_param_if.sv
// Button/status bundle for the microwave front-end controller.
// master: the panel side. It drives the buttons and door, and reads back time and status.
// slave : the controller. It samples the buttons and drives time, state, power and the actuators.
// Signals:
//   start/stop/pause/plus/minus  level buttons (edge-detected inside the controller)
//   door                         1 = door open (level)
//   sel_power                    1 = plus/minus adjust power, 0 = adjust time
//   adj_mode                     time step 0=1 s, 1=10 s, 2=1 min, 3=10 min
//   min/sec                      binary mm:ss
//   state                        0=IDLE 1=RUN 2=PAUSE 3=DONE
//   level                        power level 0..N_LEVELS-1
//   magnetron_on/lamp/beep/done  actuators and end-of-cycle pulse
interface microondas_ctrl_param_if #(
    parameter int N_LEVELS = 4
);
    localparam int LW = (N_LEVELS > 2) ? $clog2(N_LEVELS) : 1;

    logic          start;
    logic          stop;
    logic          pause;
    logic          door;
    logic          plus;
    logic          minus;
    logic          sel_power;
    logic [1:0]    adj_mode;
    logic [6:0]    min;
    logic [5:0]    sec;
    logic [1:0]    state;
    logic [LW-1:0] level;
    logic          magnetron_on;
    logic          lamp;
    logic          beep;
    logic          done;

    modport master (
        output start, stop, pause, door, plus, minus, sel_power, adj_mode,
        input  min, sec, state, level, magnetron_on, lamp, beep, done
    );

    modport slave (
        input  start, stop, pause, door, plus, minus, sel_power, adj_mode,
        output min, sec, state, level, magnetron_on, lamp, beep, done
    );
endinterface

// File: rtl/microondas_ctrl_param.sv
// Microwave front-end controller: button edge detection, IDLE/RUN/PAUSE/DONE
// sequencing, saturating mm:ss entry, 1 s countdown, N-level power duty cycling,
// door interlock and timed end-of-cycle beeper. It produces binary time and status only.
// Ports:
//   clock  system clock, rising edge
//   reset  asynchronous, active-low
//   bus    microondas_ctrl_param_if.slave (buttons in; time/status/actuators out)
module microondas_ctrl_param #(
    parameter int CLK_HZ      = 100000000,
    parameter int N_LEVELS    = 4,
    parameter int MAX_MIN     = 99,
    parameter int BEEP_CYCLES = 3 * CLK_HZ
) (
    input  logic                          clock,
    input  logic                          reset,
    microondas_ctrl_param_if.slave        bus
);
    localparam int LW    = (N_LEVELS > 2) ? $clog2(N_LEVELS) : 1;
    localparam int PW    = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam int BW    = $clog2(BEEP_CYCLES + 1);
    localparam int T_MAX = MAX_MIN * 60 + 59;
    localparam int NB    = 5;  // start, stop, pause, plus, minus

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [6:0]    min_q, min_d;
    logic [5:0]    sec_q, sec_d;
    logic [LW-1:0] level_q, level_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [LW-1:0] duty_q, duty_d;
    logic [BW-1:0] beep_cnt_q, beep_cnt_d;
    logic          done_q, done_d;
    logic          beep_q, beep_d;
    logic [NB-1:0] btn, btn_q, btn_d, btn_ed;

    logic          start_ed, stop_ed, pause_ed, plus_ed, minus_ed;
    logic          tick;
    logic [LW-1:0] level_step;
    logic [6:0]    min_adj;
    logic [5:0]    sec_adj;
    int            t_cur, t_step, t_adj;

    assign btn = {bus.minus, bus.plus, bus.pause, bus.stop, bus.start};
    assign btn_d = btn;

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_edge
            assign btn_ed[gi] = btn[gi] & ~btn_q[gi];
        end
    endgenerate

    assign start_ed = btn_ed[0];
    assign stop_ed  = btn_ed[1];
    assign pause_ed = btn_ed[2];
    assign plus_ed  = btn_ed[3];
    assign minus_ed = btn_ed[4];

    assign tick = (presc_q == PW'(CLK_HZ - 1));

    // Time entry works on total seconds so that carry, borrow and clamping
    // fall out of plain arithmetic; the result is split back into mm:ss.
    always_comb begin
        t_cur = int'(min_q) * 60 + int'(sec_q);
        case (bus.adj_mode)
            2'd0:    t_step = 1;
            2'd1:    t_step = 10;
            2'd2:    t_step = 60;
            default: t_step = 600;
        endcase
        if (plus_ed)
            t_adj = (t_cur + t_step > T_MAX) ? T_MAX : t_cur + t_step;
        else if (minus_ed)
            t_adj = (t_cur < t_step) ? 0 : t_cur - t_step;
        else
            t_adj = t_cur;
        min_adj = 7'(t_adj / 60);
        sec_adj = 6'(t_adj % 60);
    end

    always_comb begin
        if (plus_ed)
            level_step = (level_q == LW'(N_LEVELS - 1)) ? level_q : level_q + LW'(1);
        else if (minus_ed)
            level_step = (level_q == '0) ? level_q : level_q - LW'(1);
        else
            level_step = level_q;
    end

    always_comb begin
        state_d    = state_q;
        min_d      = min_q;
        sec_d      = sec_q;
        level_d    = level_q;
        presc_d    = presc_q;
        duty_d     = duty_q;
        beep_cnt_d = '0;
        done_d     = 1'b0;
        beep_d     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (stop_ed) begin
                    min_d = '0;
                    sec_d = '0;
                end else if (start_ed && !bus.door && t_cur != 0) begin
                    state_d = S_RUN;
                    presc_d = '0;
                    duty_d  = '0;
                end else if (bus.sel_power) begin
                    level_d = level_step;
                end else begin
                    min_d = min_adj;
                    sec_d = sec_adj;
                end
            end
            S_RUN: begin
                // The prescaler only advances in cycles that stay in RUN, so a
                // pause never swallows part of a second.
                if (stop_ed) begin
                    state_d = S_IDLE;
                    min_d   = '0;
                    sec_d   = '0;
                end else if (bus.door || pause_ed) begin
                    state_d = S_PAUSE;
                end else if (tick) begin
                    presc_d = '0;
                    duty_d  = (duty_q == LW'(N_LEVELS - 1)) ? '0 : duty_q + LW'(1);
                    if (sec_q != '0) begin
                        sec_d = sec_q - 6'd1;
                    end else begin
                        min_d = min_q - 7'd1;
                        sec_d = 6'd59;
                    end
                    if (t_cur == 1) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        beep_d  = 1'b1;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            S_PAUSE: begin
                if (stop_ed) begin
                    state_d = S_IDLE;
                    min_d   = '0;
                    sec_d   = '0;
                end else if (start_ed && !bus.door) begin
                    state_d = S_RUN;
                end else if (bus.sel_power) begin
                    level_d = level_step;
                end
            end
            S_DONE: begin
                // beep_cnt_q counts DONE cycles; beep stays high for exactly BEEP_CYCLES of them.
                if (stop_ed || bus.door || beep_cnt_q == BW'(BEEP_CYCLES - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    beep_d     = 1'b1;
                    beep_cnt_d = beep_cnt_q + BW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            min_q      <= '0;
            sec_q      <= '0;
            level_q    <= '0;
            presc_q    <= '0;
            duty_q     <= '0;
            beep_cnt_q <= '0;
            done_q     <= 1'b0;
            beep_q     <= 1'b0;
            btn_q      <= '0;
        end else begin
            state_q    <= state_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            level_q    <= level_d;
            presc_q    <= presc_d;
            duty_q     <= duty_d;
            beep_cnt_q <= beep_cnt_d;
            done_q     <= done_d;
            beep_q     <= beep_d;
            btn_q      <= btn_d;
        end
    end

    assign bus.min   = min_q;
    assign bus.sec   = sec_q;
    assign bus.state = state_q;
    assign bus.level = level_q;
    assign bus.done  = done_q;
    assign bus.beep  = beep_q;
    // Door term is deliberately combinational so the magnetron drops in the same cycle the door opens.
    assign bus.magnetron_on = (state_q == S_RUN) & ~bus.door & (duty_q <= level_q);
    assign bus.lamp         = bus.door | (state_q == S_RUN);
endmodule

// File: tb/tb_microondas_ctrl_param.sv
// Testbench for microondas_ctrl_param (CLK_HZ=10, N_LEVELS=4, MAX_MIN=99, BEEP_CYCLES=30).
// Table of IDLE adjustments, hand-written multi-cycle sequences, then randomized
// stimulus compared against a total-seconds reference model.
module tb_microondas_ctrl_param;
    localparam int CLK_HZ = 10;
    localparam int NL     = 4;
    localparam int MAXM   = 99;
    localparam int BEEPC  = 30;
    localparam int T_MAX  = MAXM * 60 + 59;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    microondas_ctrl_param_if #(.N_LEVELS(NL)) bus ();

    microondas_ctrl_param #(
        .CLK_HZ(CLK_HZ), .N_LEVELS(NL), .MAX_MIN(MAXM), .BEEP_CYCLES(BEEPC)
    ) dut (
        .clock(clk),
        .reset(rst_n),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int mode;
        bit sp;
        bit pl;
        bit mn;
        int emin;
        int esec;
        int elvl;
    } vec_t;

    vec_t tbl[17];

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic press(input int which);
        case (which)
            0: bus.plus  = 1'b1;
            1: bus.minus = 1'b1;
            2: bus.start = 1'b1;
            3: bus.stop  = 1'b1;
            default: bus.pause = 1'b1;
        endcase
        cyc();
        bus.plus = 1'b0; bus.minus = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0;
        cyc();
    endtask

    task automatic adj(input int mode, input bit sp, input int which, input int n);
        bus.adj_mode  = 2'(mode);
        bus.sel_power = sp;
        repeat (n) press(which);
        bus.sel_power = 1'b0;
        bus.adj_mode  = 2'd0;
    endtask

    // ---------------- reference model (total seconds, elapsed seconds) ----------------
    int m_state, m_T, m_level, m_sub, m_elapsed, m_beep_left;
    bit m_done;
    bit p_start, p_stop, p_pause, p_plus, p_minus;

    task automatic model_reset();
        m_state = 0; m_T = 0; m_level = 0; m_sub = 0; m_elapsed = 0; m_beep_left = 0;
        m_done = 0;
        p_start = 0; p_stop = 0; p_pause = 0; p_plus = 0; p_minus = 0;
    endtask

    task automatic model_level(input bit e_pl, input bit e_mn);
        if (e_pl)      m_level = (m_level + 1 > NL - 1) ? NL - 1 : m_level + 1;
        else if (e_mn) m_level = (m_level - 1 < 0) ? 0 : m_level - 1;
    endtask

    task automatic model_step();
        bit e_st, e_sp, e_pa, e_pl, e_mn;
        int step;
        e_st = bus.start && !p_start;
        e_sp = bus.stop  && !p_stop;
        e_pa = bus.pause && !p_pause;
        e_pl = bus.plus  && !p_plus;
        e_mn = bus.minus && !p_minus;
        p_start = bus.start; p_stop = bus.stop; p_pause = bus.pause;
        p_plus = bus.plus; p_minus = bus.minus;
        step = (bus.adj_mode == 2'd0) ? 1 : (bus.adj_mode == 2'd1) ? 10 :
               (bus.adj_mode == 2'd2) ? 60 : 600;
        m_done = 0;
        case (m_state)
            0: begin
                if (e_sp) m_T = 0;
                else if (e_st && !bus.door && m_T > 0) begin
                    m_state = 1; m_sub = 0; m_elapsed = 0;
                end else if (bus.sel_power) model_level(e_pl, e_mn);
                else if (e_pl) m_T = (m_T + step > T_MAX) ? T_MAX : m_T + step;
                else if (e_mn) m_T = (m_T < step) ? 0 : m_T - step;
            end
            1: begin
                if (e_sp) begin m_state = 0; m_T = 0; end
                else if (bus.door || e_pa) m_state = 2;
                else if (m_sub == CLK_HZ - 1) begin
                    m_sub = 0;
                    m_elapsed = m_elapsed + 1;
                    m_T = m_T - 1;
                    if (m_T == 0) begin m_state = 3; m_done = 1; m_beep_left = BEEPC; end
                end else m_sub = m_sub + 1;
            end
            2: begin
                if (e_sp) begin m_state = 0; m_T = 0; end
                else if (e_st && !bus.door) m_state = 1;
                else if (bus.sel_power) model_level(e_pl, e_mn);
            end
            default: begin
                if (e_sp || bus.door) m_state = 0;
                else begin
                    m_beep_left = m_beep_left - 1;
                    if (m_beep_left == 0) m_state = 0;
                end
            end
        endcase
    endtask

    initial begin
        int cnt;
        int guard;
        int prev_state;
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        bus.start = 0; bus.stop = 0; bus.pause = 0; bus.door = 0;
        bus.plus = 0; bus.minus = 0; bus.sel_power = 0; bus.adj_mode = 2'd0;

        //                mode sp pl mn  min sec lvl
        tbl[0]  = '{0, 0, 0, 1, 0, 0, 0};   // minus at 00:00 stays
        tbl[1]  = '{0, 0, 1, 0, 0, 1, 0};
        tbl[2]  = '{1, 0, 1, 0, 0, 11, 0};
        tbl[3]  = '{2, 0, 1, 0, 1, 11, 0};
        tbl[4]  = '{0, 0, 0, 1, 1, 10, 0};
        tbl[5]  = '{1, 0, 0, 1, 1, 0, 0};
        tbl[6]  = '{0, 0, 0, 1, 0, 59, 0};  // borrow
        tbl[7]  = '{0, 0, 1, 1, 1, 0, 0};   // plus wins over minus
        tbl[8]  = '{2, 0, 0, 1, 0, 0, 0};   // clamp at 0
        tbl[9]  = '{0, 1, 1, 0, 0, 0, 1};
        tbl[10] = '{0, 1, 1, 0, 0, 0, 2};
        tbl[11] = '{0, 1, 1, 0, 0, 0, 3};
        tbl[12] = '{0, 1, 1, 0, 0, 0, 3};   // level saturates high
        tbl[13] = '{0, 1, 0, 1, 0, 0, 2};
        tbl[14] = '{3, 0, 1, 0, 10, 0, 2};
        tbl[15] = '{3, 0, 0, 1, 0, 0, 2};
        tbl[16] = '{2, 0, 0, 1, 0, 0, 2};

        // ---------------- reset state ----------------
        repeat (3) cyc();
        check("rst_state", bus.state, 0);
        check("rst_min", bus.min, 0);
        check("rst_sec", bus.sec, 0);
        check("rst_level", bus.level, 0);
        check("rst_beep", bus.beep, 0);
        check("rst_done", bus.done, 0);
        check("rst_mag", bus.magnetron_on, 0);
        check("rst_lamp", bus.lamp, 0);
        rst_n = 1'b1;
        cyc();

        // ---------------- table-driven IDLE adjustments ----------------
        for (int i = 0; i < 17; i++) begin
            bus.adj_mode = 2'(tbl[i].mode);
            bus.sel_power = tbl[i].sp;
            bus.plus = tbl[i].pl;
            bus.minus = tbl[i].mn;
            cyc();
            bus.plus = 0; bus.minus = 0;
            cyc();
            $display("vec %0d: mode=%0d sel=%0d plus=%0d minus=%0d -> %0d:%0d level %0d",
                     i, tbl[i].mode, tbl[i].sp, tbl[i].pl, tbl[i].mn, bus.min, bus.sec, bus.level);
            check("tbl_min", bus.min, tbl[i].emin);
            check("tbl_sec", bus.sec, tbl[i].esec);
            check("tbl_level", bus.level, tbl[i].elvl);
        end
        bus.sel_power = 0; bus.adj_mode = 2'd0;

        // ---------------- basic 00:03 countdown, done and beep ----------------
        adj(0, 0, 0, 3);
        check("cd_set_sec", bus.sec, 3);
        bus.start = 1; cyc(); bus.start = 0;
        check("cd_state_run", bus.state, 1);
        for (int k = 1; k <= 31; k++) begin
            cyc();
            if (k == 10) check("cd_sec_c10", bus.sec, 2);
            if (k == 20) check("cd_sec_c20", bus.sec, 1);
            if (k == 29) check("cd_done_c29", bus.done, 0);
            if (k == 30) begin
                check("cd_sec_c30", bus.sec, 0);
                check("cd_state_done", bus.state, 3);
                check("cd_done_c30", bus.done, 1);
                check("cd_beep_c30", bus.beep, 1);
            end
            if (k == 31) check("cd_done_c31", bus.done, 0);
        end
        cnt = 2;  // beep already seen high at cycles 30 and 31
        guard = 0;
        while (bus.beep && guard < 100) begin
            cyc();
            if (bus.beep) cnt++;
            guard++;
        end
        check("cd_beep_len", cnt, BEEPC);
        check("cd_state_idle", bus.state, 0);
        $display("seq countdown: beep held %0d cycles, state %0d", cnt, bus.state);

        // ---------------- saturation ----------------
        adj(3, 0, 0, 11);
        check("sat_min", bus.min, 99);
        check("sat_sec", bus.sec, 59);
        press(3);
        check("sat_stop_min", bus.min, 0);
        adj(1, 0, 0, 5);
        adj(0, 0, 0, 5);
        check("c55_sec", bus.sec, 55);
        adj(1, 0, 0, 1);
        check("c55_min", bus.min, 1);
        check("c55_sec2", bus.sec, 5);
        $display("seq saturation: 00:55 +10 s -> %0d:%0d", bus.min, bus.sec);
        press(3);

        // ---------------- duty cycle, level 1 ----------------
        adj(0, 1, 1, 1);
        check("duty_level1", bus.level, 1);
        adj(0, 0, 0, 8);
        bus.start = 1; cyc(); bus.start = 0;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            check("duty1_mag", bus.magnetron_on, ((k / 10) % 4 <= 1) ? 1 : 0);
            if (bus.magnetron_on) cnt++;
            cyc();
        end
        check("duty1_count", cnt, 20);
        $display("seq duty level 1: magnetron high %0d of 40 cycles", cnt);
        press(3);
        check("duty1_stop_state", bus.state, 0);

        // ---------------- level 3, door mid-run, resume ----------------
        adj(0, 1, 0, 2);
        check("duty_level3", bus.level, 3);
        adj(0, 0, 0, 5);
        bus.start = 1; cyc(); bus.start = 0;
        cnt = 0;
        for (int k = 0; k < 15; k++) begin
            if (bus.magnetron_on) cnt++;
            cyc();
        end
        check("duty3_count", cnt, 15);
        bus.door = 1; #1;
        check("door_mag_same", bus.magnetron_on, 0);
        check("door_lamp", bus.lamp, 1);
        check("door_state_still_run", bus.state, 1);
        cyc();
        check("door_pause", bus.state, 2);
        check("door_sec", bus.sec, 4);
        bus.door = 0; cyc();
        check("door_closed_pause", bus.state, 2);
        bus.door = 1; bus.start = 1; cyc(); bus.start = 0; cyc();
        check("door_start_ignored", bus.state, 2);
        bus.door = 0; cyc();
        bus.start = 1; cyc(); bus.start = 0;
        check("resume_state", bus.state, 1);
        repeat (4) cyc();
        check("resume_sec_c4", bus.sec, 4);
        cyc();
        check("resume_sec_c5", bus.sec, 3);
        $display("seq door: resumed, 00:%0d after 5 cycles", bus.sec);

        // ---------------- stop+pause together, start at T=0 ----------------
        bus.stop = 1; bus.pause = 1; cyc(); bus.stop = 0; bus.pause = 0;
        check("sp_state", bus.state, 0);
        check("sp_min", bus.min, 0);
        check("sp_sec", bus.sec, 0);
        bus.start = 1; cyc(); bus.start = 0; cyc();
        check("t0_start_ignored", bus.state, 0);

        // ---------------- async reset mid-run, held button ----------------
        adj(0, 0, 0, 2);
        bus.start = 1; cyc(); bus.start = 0;
        repeat (3) cyc();
        check("ar_mag_before", bus.magnetron_on, 1);
        rst_n = 0; bus.plus = 1; #1;
        check("ar_state", bus.state, 0);
        check("ar_mag", bus.magnetron_on, 0);
        check("ar_lamp", bus.lamp, 0);
        check("ar_sec", bus.sec, 0);
        check("ar_level", bus.level, 0);
        cyc();
        rst_n = 1;
        repeat (5) cyc();
        check("held_one_edge", bus.sec, 1);
        $display("seq reset: plus held across release -> 00:%0d", bus.sec);
        bus.plus = 0;

        // ---------------- randomized run against the model ----------------
        rst_n = 0; cyc(); rst_n = 1;
        model_reset();
        prev_state = 0;
        for (int i = 0; i < 2500; i++) begin
            bus.start = ($urandom_range(0, 5) == 0);
            bus.stop = ($urandom_range(0, 79) == 0);
            bus.pause = ($urandom_range(0, 39) == 0);
            bus.plus = ($urandom_range(0, 3) == 0);
            bus.minus = ($urandom_range(0, 7) == 0);
            bus.sel_power = ($urandom_range(0, 3) == 0);
            bus.adj_mode = ($urandom_range(0, 9) < 7) ? 2'd0 : 2'($urandom_range(1, 3));
            if (bus.door) begin
                if ($urandom_range(0, 7) == 0) bus.door = 0;
            end else if ($urandom_range(0, 59) == 0) bus.door = 1;
            #1;
            check("rnd_mag", bus.magnetron_on,
                  (m_state == 1 && !bus.door && (m_elapsed % NL) <= m_level) ? 1 : 0);
            check("rnd_lamp", bus.lamp, (bus.door || m_state == 1) ? 1 : 0);
            model_step();
            cyc();
            check("rnd_state", bus.state, m_state);
            check("rnd_min", bus.min, m_T / 60);
            check("rnd_sec", bus.sec, m_T % 60);
            check("rnd_level", bus.level, m_level);
            check("rnd_done", bus.done, m_done ? 1 : 0);
            check("rnd_beep", bus.beep, (m_state == 3) ? 1 : 0);
            if (m_state != prev_state)
                $display("rnd %0d: state %0d -> %0d, T=%0d s, level %0d",
                         i, prev_state, m_state, m_T, m_level);
            prev_state = m_state;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
